// File: rtl/multiplicador_sat.sv
// Sequential signed Q-format multiplier: MSB-first shift-add on magnitudes, then shift by F with saturation to +/-(2^L-1).
// Optional build macro REDONDEO_EN selects round-half-away-from-zero instead of truncation; latency is the same either way.
module multiplicador_sat #(
   parameter int unsigned L = 24,
   parameter int unsigned F = 12
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [L:0]   a,
   input  logic [L:0]   b,
   output logic         ready,
   output logic         done,
   output logic [L:0]   y,
   output logic         sat
);

   localparam int unsigned W  = L + 1;
   localparam int unsigned PW = 2 * L + 2;
   localparam int unsigned CW = $clog2(L + 1);

`ifdef REDONDEO_EN
   localparam logic [PW-1:0] RND = PW'(1) << (F - 1);
`else
   localparam logic [PW-1:0] RND = '0;
`endif

   localparam logic [W-1:0] Y_POS_MAX = {1'b0, {L{1'b1}}};
   localparam logic [W-1:0] Y_NEG_MAX = {1'b1, {(L - 1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, CALC, SAT, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    ma_q, ma_d;
   logic [W-1:0]    mb_q, mb_d;
   logic            sign_q, sign_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [W-1:0]    y_q, y_d;
   logic            sat_q, sat_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;

   logic [PW-1:0]   rnd_c;
   logic [PW-1:0]   m_c;
   logic            ovf_c;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ma_q    <= '0;
         mb_q    <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         sat_q   <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         sign_q  <= sign_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         sat_q   <= sat_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      sign_d  = sign_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      y_d     = y_q;
      sat_d   = sat_q;

      // Overflow means any bit at or above position L survives the shift
      rnd_c = acc_q + RND;
      m_c   = rnd_c >> F;
      ovf_c = |m_c[PW-1:L];

      unique case (state_q)
         IDLE: begin
            if (start) begin
               ma_d    = a[L] ? (W'(0) - a) : a;
               mb_d    = b[L] ? (W'(0) - b) : b;
               sign_d  = a[L] ^ b[L];
               cnt_d   = CW'(L);
               acc_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = {acc_q[PW-2:0], 1'b0} + (mb_q[cnt_q] ? PW'(ma_q) : PW'(0));
            if (cnt_q == '0) begin
               state_d = SAT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SAT: begin
            if (ovf_c) begin
               y_d   = sign_q ? Y_NEG_MAX : Y_POS_MAX;
               sat_d = 1'b1;
            end else begin
               y_d   = sign_q ? (W'(0) - m_c[L:0]) : m_c[L:0];
               sat_d = 1'b0;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign y     = y_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_multiplicador_sat.sv
// Self-checking bench for multiplicador_sat: directed corner operands plus random operands against an arithmetic model.
module tb_multiplicador_sat;

   localparam int unsigned L   = 24;
   localparam int unsigned F   = 12;
   localparam int unsigned LAT = L + 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [L:0]    a;
   logic [L:0]    b;
   logic          ready;
   logic          done;
   logic [L:0]    y;
   logic          sat;

   int n_tests = 0;
   int n_fail  = 0;

   multiplicador_sat #(.L(L), .F(F)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
      .y       (y),
      .sat     (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: exact signed product, magnitude scaled by 2^-F, then clip
   task automatic model(input logic [L:0] ta, input logic [L:0] tb_v,
                        output longint ey, output longint esat);
      longint sa, sb, p, mag, m, lim;
      sa  = longint'($signed(ta));
      sb  = longint'($signed(tb_v));
      p   = sa * sb;
      mag = (p < 0) ? -p : p;
`ifdef REDONDEO_EN
      mag = mag + (longint'(1) << (F - 1));
`endif
      m   = mag / (longint'(1) << F);
      lim = (longint'(1) << L) - 1;
      if (m > lim) begin
         esat = 1;
         ey   = (p < 0) ? -lim : lim;
      end else begin
         esat = 0;
         ey   = (p < 0) ? -m : m;
      end
   endtask

   function automatic longint sy(input logic [L:0] v);
      return longint'($signed(v));
   endfunction

   // One multiply; optionally re-pulse start mid-CALC with other operands
   task automatic run_op(input string tag, input logic [L:0] ta, input logic [L:0] tb_v,
                         input bit inject);
      longint ey, esat;
      int     cyc;
      bit     ready_low;
      model(ta, tb_v, ey, esat);
      check({tag, "_ready_before"}, longint'(ready), 1);
      a = ta; b = tb_v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = L'($urandom); b = L'($urandom);
      cyc = 0;
      ready_low = 1'b1;
      for (int i = 1; i <= 3 * LAT && cyc == 0; i++) begin
         if (inject && i == 5) begin
            start = 1'b1; a = ~ta; b = 25'd7;
         end
         if (inject && i == 6) start = 1'b0;
         @(posedge clk); #1;
         if (done) cyc = i;
         else if (ready) ready_low = 1'b0;
      end
      check({tag, "_latency"}, longint'(cyc), longint'(LAT));
      check({tag, "_ready_busy"}, longint'(ready_low), 1);
      check({tag, "_y"}, sy(y), ey);
      check({tag, "_sat"}, longint'(sat), esat);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, longint'(done), 0);
      check({tag, "_ready_after"}, longint'(ready), 1);
      check({tag, "_y_hold"}, sy(y), ey);
   endtask

   initial begin
      logic [L:0] ra, rb;
      bit         no_done;
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_ready", longint'(ready), 1);
      check("rst_done",  longint'(done), 0);
      check("rst_y",     sy(y), 0);
      check("rst_sat",   longint'(sat), 0);

      run_op("one_x_one",  25'(4096),  25'(4096), 1'b0);
      run_op("neg_mul",    25'(-6144), 25'(8192), 1'b0);
      run_op("neg_small",  25'(-3),    25'(2048), 1'b0);
      run_op("pos_small",  25'(3),     25'(2048), 1'b0);
      run_op("sat_pos",    25'(1 << 23), 25'(1 << 23), 1'b0);
      run_op("sat_neg",    25'h1000000, 25'((1 << 24) - 1), 1'b0);
      run_op("zero_neg",   25'(0),     25'(-5), 1'b0);
      run_op("min_x_min",  25'h1000000, 25'h1000000, 1'b0);
      run_op("inject",     25'(-12345), 25'(6789), 1'b1);

      // Reset mid-CALC discards the operation
      check("pre_rst_y_nonzero", longint'(y != '0), 1);
      a = 25'(5000); b = 25'(7000); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("midrst_ready", longint'(ready), 1);
      check("midrst_done",  longint'(done), 0);
      check("midrst_y",     sy(y), 0);
      check("midrst_sat",   longint'(sat), 0);
      no_done = 1'b1;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(posedge clk); #1;
         if (done) no_done = 1'b0;
      end
      check("midrst_no_done", longint'(no_done), 1);
      run_op("after_rst", 25'(5000), 25'(7000), 1'b0);

      // Random operands: mix of small-magnitude and full-range
      for (int k = 0; k < 24; k++) begin
         if (k % 2 == 0) begin
            ra = 25'($urandom_range(0, 1 << 14)) * ((($urandom % 2) == 0) ? 25'(1) : 25'(-1));
            rb = 25'($urandom_range(0, 1 << 14)) * ((($urandom % 2) == 0) ? 25'(1) : 25'(-1));
         end else begin
            ra = 25'($urandom);
            rb = 25'($urandom_range(0, 1 << 12)) * ((($urandom % 2) == 0) ? 25'(1) : 25'(-1));
         end
         run_op($sformatf("rand%0d", k), ra, rb, (k % 5) == 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplicador_sat.md
MULTIPLICADOR_SAT -- requirements
Module: multiplicador_sat

Interface
REQ-001 Parameter L, default 24, data words are L+1 bits signed two's complement (matches downstream saturating adder).
REQ-002 Parameter F, default 12, fractional bits of the Q format shared by a, b and y.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to multiply a by b.
REQ-006 a  input  L+1  signed multiplicand.
REQ-007 b  input  L+1  signed multiplier.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse marking y/sat valid.
REQ-010 y  output  L+1  signed saturated product, feeds adder input a or b.
REQ-011 sat  output  1  high when y was clipped.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC, SAT, DONE.
REQ-013 In IDLE, ready=1; on an edge with start=1, a and b SHALL be captured as magnitudes |a|, |b| (L+1 bits unsigned) plus sign = a[L] xor b[L], state -> CALC, ready -> 0.
REQ-014 start SHALL be ignored in every state other than IDLE; a, b changes after capture SHALL not affect the result.
REQ-015 CALC SHALL perform unsigned shift-add, one multiplier bit per cycle, for exactly L+1 cycles (down-counter L..0), accumulating into a 2L+2-bit magnitude register, then -> SAT.
REQ-016 SAT SHALL compute m = magnitude >> F (truncation toward zero, see REQ-024), one cycle, then -> DONE.
REQ-017 If m > 2^L-1: sign=0 gives y = {0, L ones} = +(2^L-1); sign=1 gives y = {1, (L-1) zeros, 1} = -(2^L-1); sat=1.
REQ-018 Otherwise y = sign ? -m : m, sat=0; m=0 SHALL give y=0 regardless of sign.
REQ-019 y and sat SHALL be registered on entry to DONE; done=1 for exactly the DONE cycle; next edge -> IDLE, ready=1.
REQ-020 Latency: done high in the cycle following the (L+2)th edge after acceptance (26 cycles for L=24); back-to-back throughput one result per L+4 cycles.
REQ-021 y and sat SHALL hold their last value until the next DONE entry.
REQ-022 Operand -2^L SHALL be handled (magnitude 2^L fits L+1 unsigned bits).

Reset
REQ-023 On an edge with reset_n=0, from any state incl. mid-CALC: state=IDLE, ready=1, done=0, y=0, sat=0, counter and accumulator cleared; in-flight operation discarded, no done pulse.

Configuration
REQ-024 Macro REDONDEO_EN: when defined, SAT SHALL add 2^(F-1) to the magnitude before the shift (round half away from zero, saturation checked after rounding); when undefined, plain truncation toward zero; latency unchanged either way.

Verification
REQ-025 F=12, a=4096, b=4096, start -> after 26 cycles done=1, y=4096, sat=0.
REQ-026 a=-6144, b=8192 -> y=-12288, sat=0; a=-3, b=2048 -> y=-1 (truncation) or -2 (REDONDEO_EN); a=3, b=2048 -> 1 or 2.
REQ-027 a=2^23, b=2^23 -> y=+16777215, sat=1; a=-2^24, b=2^24-1 -> y=-16777215, sat=1; a=0, b=-5 -> y=0.
REQ-028 Pulse start again with different operands at cycle 5 of CALC -> ignored, result matches first operands, ready low until DONE completes.
REQ-029 reset_n=0 for one edge at cycle 10 of CALC -> ready=1, done never pulses, y=0, sat=0; new start afterwards completes normally.
